// File: rtl/uart_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_ram_loader
// Brief    : Receives a length-prefixed 8N1 UART image and writes it into RAM
//            while holding the CPU in reset.
// Revision : 1.0 - initial release
// ============================================================================
module uart_ram_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_qzt,
    input  logic       reset_n,
    input  logic       rx_in,
    input  logic       start,
    output logic       cpu_hold,
    output logic       ram_write_en,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       busy,
    output logic       done,
    output logic       frame_err,
    output logic [8:0] byte_count
);
    localparam int                c_TW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_TW-1:0]   c_FULL = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0]   c_HALF = c_TW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
    localparam logic [1:0] L_IDLE = 2'd0, L_LEN = 2'd1, L_DATA = 2'd2, L_DONE = 2'd3;

    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]      r_rx_state, w_rx_next;
    logic [c_TW-1:0] r_timer;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_byte_valid, r_byte_err;
    logic            w_tick_full, w_tick_half, w_timer_clr, w_shift, w_stop_sample;

    logic [1:0]      r_ld_state, w_ld_next;
    logic [8:0]      r_len;
    logic            w_load_start, w_latch_len, w_take;

    // ---------------- receiver ----------------
    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) r_rx_state <= R_IDLE;
        else          r_rx_state <= w_rx_next;
    end

    assign w_tick_full = (r_timer == c_FULL);
    assign w_tick_half = (r_timer == c_HALF);

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = R_START;
            R_START: if (w_tick_half) w_rx_next = r_rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (w_tick_full && (r_bit_idx == 3'd7)) w_rx_next = R_STOP;
            R_STOP:  if (w_tick_full) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_timer_clr   = (r_rx_state == R_IDLE) ||
                        ((r_rx_state == R_START) && w_tick_half) ||
                        ((r_rx_state == R_DATA) && w_tick_full);
        w_shift       = (r_rx_state == R_DATA) && w_tick_full;
        w_stop_sample = (r_rx_state == R_STOP) && w_tick_full;
    end

    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) begin
            r_timer      <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_byte_valid <= 1'b0;
            r_byte_err   <= 1'b0;
        end else begin
            r_timer <= w_timer_clr ? '0 : r_timer + c_TW'(1);
            if (r_rx_state == R_IDLE) r_bit_idx <= 3'd0;
            else if (w_shift)         r_bit_idx <= r_bit_idx + 3'd1;
            if (w_shift) r_shift <= {r_rx_sync, r_shift[7:1]};
            r_byte_valid <= w_stop_sample && r_rx_sync;
            r_byte_err   <= w_stop_sample && !r_rx_sync;
        end
    end

    // ---------------- loader ----------------
    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) r_ld_state <= L_IDLE;
        else          r_ld_state <= w_ld_next;
    end

    always_comb begin
        w_ld_next = r_ld_state;
        case (r_ld_state)
            L_IDLE: if (start) w_ld_next = L_LEN;
            L_LEN:  if (r_byte_err) w_ld_next = L_IDLE;
                    else if (r_byte_valid) w_ld_next = L_DATA;
            L_DATA: if (r_byte_err) w_ld_next = L_IDLE;
                    else if (byte_count == r_len) w_ld_next = L_DONE;
            L_DONE: w_ld_next = L_IDLE;
            default: w_ld_next = L_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_ld_state != L_IDLE);
        cpu_hold     = (r_ld_state == L_LEN) || (r_ld_state == L_DATA);
        done         = (r_ld_state == L_DONE);
        w_load_start = (r_ld_state == L_IDLE) && start;
        w_latch_len  = (r_ld_state == L_LEN) && r_byte_valid;
        w_take       = (r_ld_state == L_DATA) && r_byte_valid && (byte_count != r_len);
    end

    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) begin
            ram_write_en <= 1'b0;
            ram_addr     <= 8'd0;
            ram_data     <= 8'd0;
            byte_count   <= 9'd0;
            frame_err    <= 1'b0;
            r_len        <= 9'd0;
        end else begin
            ram_write_en <= w_take;
            if (w_take) begin
                ram_data <= r_shift;
                ram_addr <= byte_count[7:0];
            end
            if (r_byte_err) frame_err <= 1'b1;
            // A new load request wins over a stray error in the same cycle
            if (w_load_start) begin
                byte_count <= 9'd0;
                ram_addr   <= 8'd0;
                frame_err  <= 1'b0;
            end else if (ram_write_en) begin
                byte_count <= byte_count + 9'd1;
            end
            if (w_latch_len) r_len <= (r_shift == 8'd0) ? 9'd256 : {1'b0, r_shift};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_ram_loader
// Brief    : Scoreboard bench: stimulus queues expected RAM writes, a monitor
//            pops and compares on every ram_write_en strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_ram_loader;
    localparam int CPB = 16;

    logic       clk_qzt = 1'b0, reset_n = 1'b0, rx_in = 1'b1, start = 1'b0;
    logic       cpu_hold, ram_write_en, busy, done, frame_err;
    logic [7:0] ram_addr, ram_data;
    logic [8:0] byte_count;

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0, fails = 0, done_count = 0, dc0 = 0, n = 0;
    logic prev_we = 1'b0;

    uart_ram_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk_qzt(clk_qzt), .reset_n(reset_n), .rx_in(rx_in), .start(start),
        .cpu_hold(cpu_hold), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_data(ram_data), .busy(busy), .done(done), .frame_err(frame_err),
        .byte_count(byte_count)
    );

    always #5 clk_qzt = ~clk_qzt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_qzt) begin
        if (ram_write_en) begin
            check("we_one_cycle", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_write: got addr 0x%0h data 0x%0h, expected no write", ram_addr, ram_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {24'd0, ram_addr}, {24'd0, mon_e.a});
                check("wr_data", {24'd0, ram_data}, {24'd0, mon_e.d});
            end
        end
        prev_we = ram_write_en;
        if (done) done_count++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk_qzt);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk_qzt);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk_qzt);
        end
        rx_in = stop_bit;
        repeat (CPB) @(negedge clk_qzt);
        rx_in = 1'b1;
        repeat (2) @(negedge clk_qzt);
    endtask

    task automatic pulse_start();
        @(negedge clk_qzt);
        start = 1'b1;
        @(negedge clk_qzt);
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk_qzt);
        check("rst_outputs", {20'd0, cpu_hold, ram_write_en, busy, done, frame_err, 7'd0},  32'd0);
        check("rst_addr_data", {16'd0, ram_addr, ram_data}, 32'd0);
        check("rst_count", {23'd0, byte_count}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_qzt);

        // basic 3-byte load
        dc0 = done_count;
        push(8'h00, 8'hA5); push(8'h01, 8'h5A); push(8'h02, 8'h01);
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h03, 1'b1); send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1); send_byte(8'h01, 1'b1);
        repeat (2 * CPB) @(negedge clk_qzt);
        check("t1_done", done_count - dc0, 32'd1);
        check("t1_hold_end", {31'd0, cpu_hold}, 32'd0);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_count", {23'd0, byte_count}, 32'd3);
        check("t1_q_empty", exp_q.size(), 32'd0);

        // framing error aborts
        dc0 = done_count;
        push(8'h00, 8'h11);
        pulse_start();
        send_byte(8'h02, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b0);
        repeat (2 * CPB) @(negedge clk_qzt);
        check("t2_frame_err", {31'd0, frame_err}, 32'd1);
        check("t2_hold", {31'd0, cpu_hold}, 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd0);
        check("t2_no_done", done_count - dc0, 32'd0);
        check("t2_count", {23'd0, byte_count}, 32'd1);
        check("t2_q_empty", exp_q.size(), 32'd0);
        pulse_start();
        check("t2_err_cleared", {31'd0, frame_err}, 32'd0);

        // glitch in L_LEN, then start ignored mid L_DATA
        dc0 = done_count;
        @(negedge clk_qzt);
        rx_in = 1'b0;
        repeat (CPB / 4) @(negedge clk_qzt);
        rx_in = 1'b1;
        repeat (3 * CPB) @(negedge clk_qzt);
        check("t3_still_len_busy", {30'd0, busy, cpu_hold}, 32'd3);
        check("t3_count", {23'd0, byte_count}, 32'd0);
        push(8'h00, 8'h33); push(8'h01, 8'h44); push(8'h02, 8'h55);
        send_byte(8'h03, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        repeat (CPB) @(negedge clk_qzt);
        pulse_start();
        repeat (2) @(negedge clk_qzt);
        check("t3_count_kept", {23'd0, byte_count}, 32'd2);
        check("t3_addr_kept", {24'd0, ram_addr}, 32'd1);
        send_byte(8'h55, 1'b1);
        repeat (2 * CPB) @(negedge clk_qzt);
        check("t3_done", done_count - dc0, 32'd1);
        check("t3_count_end", {23'd0, byte_count}, 32'd3);
        check("t3_q_empty", exp_q.size(), 32'd0);

        // reset mid-load
        push(8'h00, 8'h10); push(8'h01, 8'h20);
        pulse_start();
        send_byte(8'h04, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h20, 1'b1);
        repeat (CPB) @(negedge clk_qzt);
        reset_n = 1'b0;
        #1;
        check("t4_rst_flags", {27'd0, cpu_hold, ram_write_en, busy, done, frame_err}, 32'd0);
        check("t4_rst_addr_data", {16'd0, ram_addr, ram_data}, 32'd0);
        check("t4_rst_count", {23'd0, byte_count}, 32'd0);
        @(negedge clk_qzt);
        reset_n = 1'b1;
        send_byte(8'h30, 1'b1); send_byte(8'h40, 1'b1);
        repeat (2 * CPB) @(negedge clk_qzt);
        check("t4_idle", {31'd0, busy}, 32'd0);
        check("t4_count", {23'd0, byte_count}, 32'd0);
        check("t4_q_empty", exp_q.size(), 32'd0);

        // start coincident with a received byte in L_IDLE
        dc0 = done_count;
        fork
            send_byte(8'h07, 1'b1);
            begin
                n = 0;
                while (dut.r_byte_valid !== 1'b1 && n < 40 * CPB) begin
                    @(posedge clk_qzt); #1; n++;
                end
                start = 1'b1;
                @(posedge clk_qzt); #1;
                start = 1'b0;
            end
        join
        check("t5_wait_in_budget", {31'd0, (n < 40 * CPB)}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd1);
        push(8'h00, 8'h99);
        send_byte(8'h01, 1'b1); send_byte(8'h99, 1'b1);
        repeat (2 * CPB) @(negedge clk_qzt);
        check("t5_done", done_count - dc0, 32'd1);
        check("t5_count", {23'd0, byte_count}, 32'd1);
        check("t5_q_empty", exp_q.size(), 32'd0);

        // 256-byte load with length 0x00
        dc0 = done_count;
        for (int i = 0; i < 256; i++) push(8'(i), 8'(i));
        pulse_start();
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1);
        repeat (4 * CPB) @(negedge clk_qzt);
        check("t6_count", {23'd0, byte_count}, 32'd256);
        check("t6_done", done_count - dc0, 32'd1);
        check("t6_last_addr_data", {16'd0, ram_addr, ram_data}, 32'h0000FFFF);
        check("t6_hold", {31'd0, cpu_hold}, 32'd0);
        check("t6_q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
